// File: rtl/pipe_track.sv
// pipe_track: scoreboard of in-flight instructions for a short in-order
// pipeline. Each issued instruction moves one stage per enabled cycle from
// stage 0 (EXE) to stage STAGES-1 (WB), carrying its destination register and,
// from stage 1 on, its result. Two source operands of the instruction waiting
// to issue are looked up against the tracked stages to produce forwarding data
// or a load-use stall.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en                    advance enable (0 freezes all state)
//   flush                 turns the incoming stage-0 entry into a bubble
//   issue_valid/wen/ld    incoming instruction: valid, writes a reg, is a load
//   issue_waddr           incoming destination register
//   issue_ready           high when the incoming instruction is not stalled
//   src_a_addr/src_b_addr source registers of the waiting instruction
//   s0_data               live ALU result of the stage-0 entry
//   ld_data               live load data of the stage-LD_STAGE entry
//   stall                 load-use hazard on either source
//   fwd_hit_*/fwd_data_*  forwarding result per source (data 0 without hit)
//   wb_*                  entry currently in the last stage
//   busy                  any stage holds a valid entry
module pipe_track #(
  parameter int STAGES   = 3,
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LD_STAGE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          issue_valid,
  input  logic          issue_wen,
  input  logic          issue_ld,
  input  logic [AW-1:0] issue_waddr,
  output logic          issue_ready,
  input  logic [AW-1:0] src_a_addr,
  input  logic [AW-1:0] src_b_addr,
  input  logic [DW-1:0] s0_data,
  input  logic [DW-1:0] ld_data,
  output logic          stall,
  output logic          fwd_hit_a,
  output logic          fwd_hit_b,
  output logic [DW-1:0] fwd_data_a,
  output logic [DW-1:0] fwd_data_b,
  output logic          wb_valid,
  output logic          wb_wen,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_data,
  output logic          busy
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_wen;
  logic [STAGES-1:0] r_ld;
  logic [AW-1:0]     r_waddr [STAGES];
  logic [DW-1:0]     r_d     [1:STAGES-1];

  // Best currently-known result of each stage: stage 0 is still in the ALU,
  // a load in LD_STAGE has its data arriving live, all others are registered.
  logic [DW-1:0]     w_val   [STAGES];
  logic [AW-1:0]     w_src   [2];
  logic [1:0]        w_found;
  logic [1:0]        w_hazard;
  logic [DW-1:0]     w_sel   [2];
  logic              w_accept;

  assign w_src[0] = src_a_addr;
  assign w_src[1] = src_b_addr;

  // Per-stage live result value
  always_comb begin
    w_val[0] = s0_data;
    for (int s = 1; s < STAGES; s++) begin
      if ((s == LD_STAGE) && r_ld[s]) begin
        w_val[s] = ld_data;
      end else begin
        w_val[s] = r_d[s];
      end
    end
  end

  // Operand lookup: scan oldest to youngest so the youngest match wins;
  // the hazard flag therefore reflects only the selected stage.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_found[k]  = 1'b0;
      w_hazard[k] = 1'b0;
      w_sel[k]    = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (issue_valid && r_valid[s] && r_wen[s] &&
            (r_waddr[s] == w_src[k]) && (w_src[k] != '0)) begin
          w_found[k]  = 1'b1;
          w_hazard[k] = r_ld[s] && (s < LD_STAGE);
          w_sel[k]    = w_val[s];
        end else begin
          w_found[k]  = w_found[k];
          w_hazard[k] = w_hazard[k];
          w_sel[k]    = w_sel[k];
        end
      end
    end
  end

  assign stall       = |w_hazard;
  assign issue_ready = ~stall;
  assign fwd_hit_a   = w_found[0] & ~w_hazard[0];
  assign fwd_hit_b   = w_found[1] & ~w_hazard[1];
  assign fwd_data_a  = fwd_hit_a ? w_sel[0] : '0;
  assign fwd_data_b  = fwd_hit_b ? w_sel[1] : '0;

  // Flush dominates; a stalled instruction is simply not taken this cycle.
  assign w_accept = issue_valid & ~stall & ~flush;

  // Stage shift register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_wen   <= '0;
      r_ld    <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_waddr[s] <= '0;
      end
      for (int s = 1; s < STAGES; s++) begin
        r_d[s] <= '0;
      end
    end else if (en) begin
      r_valid[0] <= w_accept;
      r_wen[0]   <= w_accept & issue_wen;
      r_ld[0]    <= w_accept & issue_ld;
      r_waddr[0] <= w_accept ? issue_waddr : '0;
      r_d[1]     <= s0_data;
      for (int s = 0; s < STAGES - 1; s++) begin
        r_valid[s+1] <= r_valid[s];
        r_wen[s+1]   <= r_wen[s];
        r_ld[s+1]    <= r_ld[s];
        r_waddr[s+1] <= r_waddr[s];
      end
      for (int s = 1; s < STAGES - 1; s++) begin
        r_d[s+1] <= w_val[s];
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  assign wb_valid = r_valid[STAGES-1];
  assign wb_wen   = r_wen[STAGES-1];
  assign wb_waddr = r_waddr[STAGES-1];
  assign wb_data  = r_d[STAGES-1];
  assign busy     = |r_valid;

endmodule

// File: tb/tb_pipe_track.sv
module tb_pipe_track;

  logic        clk = 1'b0;
  logic        rst_n, en, flush, issue_valid, issue_wen, issue_ld;
  logic [4:0]  issue_waddr, src_a_addr, src_b_addr;
  logic [31:0] s0_data, ld_data;
  logic        issue_ready, stall, fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
  logic        wb_valid, wb_wen, busy;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;

  pipe_track dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_ld(issue_ld),
    .issue_waddr(issue_waddr), .issue_ready(issue_ready),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .s0_data(s0_data), .ld_data(ld_data), .stall(stall),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic l, input logic [4:0] a);
    issue_valid = 1'b1; issue_wen = w; issue_ld = l; issue_waddr = a; flush = 1'b0;
  endtask

  // Probe: present sources with a valid but flushed issue, so nothing enters.
  task automatic probe(input logic [4:0] a, input logic [4:0] b);
    issue_valid = 1'b1; issue_wen = 1'b1; issue_ld = 1'b0; issue_waddr = 5'd5;
    flush = 1'b1; src_a_addr = a; src_b_addr = b;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wen = 1'b0; issue_ld = 1'b0; issue_waddr = 5'd0;
    flush = 1'b0; src_a_addr = 5'd0; src_b_addr = 5'd0;
  endtask

  // Retire monitor: an entry leaves stage WB on each enabled, non-reset edge.
  always @(negedge clk) begin
    if (rst_n && en && wb_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL retire_unexpected: got waddr %h data %h expected none", wb_waddr, wb_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("retire_wen", {31'd0, wb_wen}, {31'd0, e.wen});
        chk("retire_waddr", {27'd0, wb_waddr}, {27'd0, e.waddr});
        chk("retire_data", wb_data, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; s0_data = 32'd0; ld_data = 32'd0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fwd_hit_a", {31'd0, fwd_hit_a}, 32'd0);
    chk("rst_fwd_data_b", fwd_data_b, 32'd0);

    // ALU chain on r8
    issue(1'b1, 1'b0, 5'd8); tick();
    s0_data = 32'h11; sb_q.push_back({1'b1, 5'd8, 32'h11});
    probe(5'd8, 5'd0); #1;
    chk("alu_hit_a_s0", {31'd0, fwd_hit_a}, 32'd1);
    chk("alu_data_a_s0", fwd_data_a, 32'h11);
    chk("alu_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    idle(); s0_data = 32'h99; tick();
    probe(5'd8, 5'd0); #1;
    chk("alu_data_a_s2", fwd_data_a, 32'h11);
    chk("alu_wb_waddr", {27'd0, wb_waddr}, 32'd8);
    chk("alu_wb_data", wb_data, 32'h11);
    tick();

    // Load-use on r9, consumer writes r4
    idle(); issue(1'b1, 1'b1, 5'd9); s0_data = 32'h0; tick();
    issue(1'b1, 1'b0, 5'd4); src_b_addr = 5'd9; #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_ready", {31'd0, issue_ready}, 32'd0);
    chk("lu_hit_b_stalled", {31'd0, fwd_hit_b}, 32'd0);
    chk("lu_data_b_stalled", fwd_data_b, 32'd0);
    tick();
    ld_data = 32'h55; sb_q.push_back({1'b1, 5'd9, 32'h55}); #1;
    chk("lu_stall_released", {31'd0, stall}, 32'd0);
    chk("lu_hit_b", {31'd0, fwd_hit_b}, 32'd1);
    chk("lu_data_b", fwd_data_b, 32'h55);
    tick();
    idle(); ld_data = 32'h0; s0_data = 32'h66; sb_q.push_back({1'b1, 5'd4, 32'h66});
    tick();

    // Youngest match wins on r3
    issue(1'b1, 1'b0, 5'd3); tick();
    idle(); s0_data = 32'hA; sb_q.push_back({1'b1, 5'd3, 32'hA}); tick();
    issue(1'b1, 1'b0, 5'd3); tick();
    s0_data = 32'hB; sb_q.push_back({1'b1, 5'd3, 32'hB});
    probe(5'd3, 5'd2); #1;
    chk("young_data_a", fwd_data_a, 32'hB);
    chk("young_hit_b_miss", {31'd0, fwd_hit_b}, 32'd0);
    tick();

    // Register 0 never forwards; flushed issue leaves a bubble
    issue(1'b1, 1'b0, 5'd0); tick();
    s0_data = 32'h77; sb_q.push_back({1'b1, 5'd0, 32'h77});
    probe(5'd0, 5'd0); #1;
    chk("r0_hit_a", {31'd0, fwd_hit_a}, 32'd0);
    chk("r0_data_a", fwd_data_a, 32'd0);
    tick();
    probe(5'd5, 5'd0); #1;
    chk("flush_bubble_hit_a", {31'd0, fwd_hit_a}, 32'd0);
    tick();

    // Freeze with r7 in WB and r6 in stage 0
    idle(); issue(1'b1, 1'b0, 5'd7); tick();
    idle(); s0_data = 32'h21; sb_q.push_back({1'b1, 5'd7, 32'h21}); tick();
    issue(1'b1, 1'b0, 5'd6); tick();
    en = 1'b0; s0_data = 32'h31;
    probe(5'd6, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("frz_wb_waddr", {27'd0, wb_waddr}, 32'd7);
      chk("frz_wb_data", wb_data, 32'h21);
      chk("frz_fwd_data_a", fwd_data_a, 32'h31);
      tick();
    end
    en = 1'b1; idle(); sb_q.push_back({1'b1, 5'd6, 32'h31}); tick();

    // Reset with three valid entries in flight
    issue(1'b1, 1'b0, 5'd10); tick();
    issue(1'b1, 1'b0, 5'd11); s0_data = 32'h41; tick();
    issue(1'b1, 1'b0, 5'd12); s0_data = 32'h42; tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; en = 1'b0; idle(); tick();
    rst_n = 1'b1; en = 1'b1; #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("mid_rst_wb_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    issue(1'b1, 1'b0, 5'd13); tick();
    idle(); s0_data = 32'h51; sb_q.push_back({1'b1, 5'd13, 32'h51});
    tick(); tick(); tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_track.md
PIPE_TRACK -- requirements
Module: pipe_track

Interface
REQ-001 SHALL have parameter STAGES, default 3, tracked stages after issue (stage 0 = EXE, STAGES-1 = WB); legal STAGES>=3.
REQ-002 SHALL have parameter DW, default 32, result data width.
REQ-003 SHALL have parameter AW, default 5, register address width.
REQ-004 SHALL have parameter LD_STAGE, default 1, the stage in which load data is presented live; legal 1<=LD_STAGE<=STAGES-2.
REQ-005 SHALL have port clk  in  1  the single clock; every register updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port en  in  1  global advance enable; 0 freezes all state.
REQ-008 SHALL have port flush  in  1  replaces the incoming stage-0 entry with a bubble.
REQ-009 SHALL have ports issue_valid, issue_wen, issue_ld  in  1 each  incoming instruction: valid, writes a register, is a load.
REQ-010 SHALL have port issue_waddr  in  AW  destination register of the incoming instruction.
REQ-011 SHALL have port issue_ready  out  1  equal to ~stall.
REQ-012 SHALL have ports src_a_addr, src_b_addr  in  AW  source registers of the instruction waiting to issue.
REQ-013 SHALL have port s0_data  in  DW  live ALU result of the stage-0 entry.
REQ-014 SHALL have port ld_data  in  DW  live load data of the stage-LD_STAGE entry.
REQ-015 SHALL have port stall  out  1  load-use hazard on src_a or src_b.
REQ-016 SHALL have ports fwd_hit_a, fwd_hit_b  out  1  a tracked stage supplies the operand.
REQ-017 SHALL have ports fwd_data_a, fwd_data_b  out  DW  forwarded operand; 0 when no hit.
REQ-018 SHALL have ports wb_valid, wb_wen  out  1, wb_waddr  out  AW, wb_data  out  DW  retiring entry in stage STAGES-1.
REQ-019 SHALL have port busy  out  1  OR of all stage valid bits.

Function
REQ-020 SHALL hold per stage s: valid, wen, ld, waddr; and for s>=1 a DW data register d[s].
REQ-021 SHALL, when en=1, shift every entry s to s+1 (s<STAGES-1); the stage STAGES-1 entry is discarded.
REQ-022 SHALL, on shift, load d[s+1] with ld_data if s==LD_STAGE and ld[s]=1, with s0_data if s==0, else with d[s].
REQ-023 SHALL, on shift, load stage 0 with the issue entry only if issue_valid=1, stall=0 and flush=0; otherwise stage 0 becomes a bubble (valid=0, wen=0, ld=0).
REQ-024 SHALL, when en=0, hold all state; stall and forwarding outputs stay combinationally live.
REQ-025 SHALL define match(s,x) = valid[s] & wen[s] & (waddr[s]==x) & (x!=0).
REQ-026 SHALL select, per source, the youngest (lowest-index) matching stage; older matches are ignored.
REQ-027 SHALL assert stall when the selected stage s for either source has ld[s]=1 and s<LD_STAGE; fwd_hit for that source SHALL be 0.
REQ-028 SHALL otherwise set fwd_data to s0_data if s==0, to ld_data if s==LD_STAGE and ld[s]=1, else to d[s].
REQ-029 SHALL assert neither stall nor fwd_hit for address 0 or when issue_valid=0.
REQ-030 SHALL drive wb_* from stage STAGES-1 combinationally (wb_data = d[STAGES-1]).
REQ-031 SHALL give flush priority over issue; flush with stall=1 yields one bubble, no double insertion.
REQ-032 SHALL be fully pipelined: one entry per cycle, no internal latency beyond the stage shift.

Reset
REQ-033 SHALL, on rising clk with rst_n=0, clear all valid, wen, ld, waddr and d[s] to 0, regardless of en.
REQ-034 SHALL, after reset, drive stall=0, busy=0, wb_valid=0, wb_wen=0, wb_waddr=0, wb_data=0, fwd_hit_a/b=0, fwd_data_a/b=0.
REQ-035 SHALL let reset mid-operation discard all in-flight entries; first issue accepted on the first edge with rst_n=1.

Verification
REQ-036 ALU chain: issue wen, waddr=8; next cycle src_a_addr=8, s0_data=0x11 -> fwd_hit_a=1, fwd_data_a=0x11; two edges later fwd_data_a=d[2]=0x11, wb_waddr=8, wb_data=0x11.
REQ-037 Load-use: issue ld, waddr=9; next cycle src_b_addr=9 -> stall=1, issue_ready=0; after edge stage 0 bubble, ld in stage 1, ld_data=0x55 -> stall=0, fwd_data_b=0x55.
REQ-038 Youngest wins: waddr=3 in stage 2 (d=0xA) and stage 0 (s0_data=0xB), src_a_addr=3 -> fwd_data_a=0xB.
REQ-039 Register 0 / flush: waddr=0 in flight, src_a_addr=0 -> fwd_hit_a=0; flush=1 with issue_valid=1 -> stage 0 valid=0 after edge.
REQ-040 Freeze and reset: en=0 for 3 cycles -> wb_* unchanged; rst_n=0 for one edge with 3 valid entries -> busy=0, all wb_* 0.
